// File: rtl/spi_master_if.sv
// SPI master bundle: request/response handshake plus the four SPI pins.
// Latency: none, this is wiring only.
// Backpressure: none; the requester must watch busy before pulsing start.
interface spi_master_if;
    logic        start;
    logic [15:0] tx_data;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic        busy;
    logic        done;
    logic [15:0] rx_data;

    // The SPI master drives the pins and status and consumes the request.
    modport master (
        input  start, tx_data, miso,
        output sclk, mosi, cs, busy, done, rx_data
    );

    // The requester side (and the serial slave pin) is the mirror image.
    modport slave (
        output start, tx_data, miso,
        input  sclk, mosi, cs, busy, done, rx_data
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master, 16-bit word sent low byte first, MSB-first inside each byte.
// Latency: start accepted at cycle 0 -> cs high cycles 1..33*CLK_DIV, done at 33*CLK_DIV+1.
// Backpressure: start is only sampled while busy=0 (IDLE or DONE); requests while busy are dropped.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic  clk,
    input  logic  reset,
    spi_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HIGH,
        SCLK_LOW,
        HOLD,
        DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] tx_shift;
    logic [15:0] rx_shift;
    logic [15:0] rx_word;
    logic        timed;
    logic        phase_end;
    logic        accept;

    assign phase_end = (div_cnt == DIV_LAST);

    // State register; reset forces IDLE so every Moore output drops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the pin/status outputs, all derived from the current state.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        timed       = 1'b0;
        bus.sclk    = 1'b0;
        bus.cs      = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.mosi    = 1'b0;
        bus.rx_data = rx_word;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                timed = 1'b1;
                if (phase_end) state_nxt = SCLK_HIGH;
            end
            SCLK_HIGH: begin
                timed    = 1'b1;
                bus.sclk = 1'b1;
                // bit_cnt counts completed high phases; 15 means this is the 16th.
                if (phase_end) state_nxt = (bit_cnt == 4'd15) ? HOLD : SCLK_LOW;
            end
            SCLK_LOW: begin
                timed = 1'b1;
                if (phase_end) state_nxt = SCLK_HIGH;
            end
            HOLD: begin
                timed = 1'b1;
                if (phase_end) state_nxt = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                // A start seen here chains straight into the next word, leaving cs low one cycle.
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (timed) begin
            bus.cs   = 1'b1;
            bus.busy = 1'b1;
            bus.mosi = tx_shift[15];
        end
    end

    // Phase timer and shift datapath: load on accept, shift both words at the end of each high phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= 8'd0;
            bit_cnt  <= 4'd0;
            tx_shift <= 16'h0000;
            rx_shift <= 16'h0000;
            rx_word  <= 16'h0000;
        end else begin
            div_cnt <= (timed && !phase_end) ? div_cnt + 8'd1 : 8'd0;
            if (accept) begin
                // Reorder once so a plain MSB-first shift yields low byte first on the wire.
                tx_shift <= {bus.tx_data[7:0], bus.tx_data[15:8]};
            end else if (state == SCLK_HIGH && phase_end) begin
                tx_shift <= {tx_shift[14:0], 1'b0};
                rx_shift <= {rx_shift[14:0], bus.miso};
                bit_cnt  <= bit_cnt + 4'd1;
            end
            // First eight received bits are the low byte, so swap halves when publishing.
            if (state == HOLD && phase_end) begin
                rx_word <= {rx_shift[7:0], rx_shift[15:8]};
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed and randomized transfers against a word-level model.
// Latency: checks cs window and done cycle relative to the accepting edge.
// Backpressure: exercises start pulses while busy and chained starts in DONE.
module tb_spi_master;

    localparam int D = 4;

    logic clk;
    logic reset;

    spi_master_if m4();
    spi_master_if m2();
    spi_master_if m8();

    spi_master #(.CLK_DIV(4)) u_dut (.clk(clk), .reset(reset), .bus(m4.master));
    spi_master #(.CLK_DIV(2)) u_d2  (.clk(clk), .reset(reset), .bus(m2.master));
    spi_master #(.CLK_DIV(8)) u_d8  (.clk(clk), .reset(reset), .bus(m8.master));

    int n_tests = 0;
    int n_fail  = 0;

    // serial slave seen by the main DUT: either a loopback wire or a word shifted out per high phase
    bit          loopback;
    logic [15:0] slave_word;
    int          slave_k;
    logic        slave_bit;

    assign m4.miso = loopback ? m4.mosi : slave_bit;
    assign m2.miso = m2.mosi;
    assign m8.miso = m8.mosi;

    // slaves receiving from the CLK_DIV=2 and CLK_DIV=8 masters
    logic [15:0] s2_shift, s8_shift, s2_word, s8_word;
    int          s2_rises, s8_rises;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the wire carries bit i of the word as: bits 7..0 first, then bits 15..8
    function automatic logic wire_bit(input logic [15:0] w, input int i);
        logic [15:0] v;
        v = w;
        if (i < 8) return v[7 - i];
        return v[23 - i];
    endfunction

    function automatic logic [15:0] wire_seq(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15 - i] = wire_bit(w, i);
        return r;
    endfunction

    always @(posedge m4.sclk) begin
        if (slave_k < 16) slave_bit = wire_bit(slave_word, slave_k);
        slave_k++;
    end

    always @(posedge m2.sclk) begin
        s2_shift = {s2_shift[14:0], m2.mosi};
        s2_rises++;
    end
    always @(posedge m8.sclk) begin
        s8_shift = {s8_shift[14:0], m8.mosi};
        s8_rises++;
    end
    always @(negedge m2.cs) s2_word = {s2_shift[7:0], s2_shift[15:8]};
    always @(negedge m8.cs) s8_word = {s8_shift[7:0], s8_shift[15:8]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one complete transfer on the CLK_DIV=4 DUT, observed once per cycle on the falling edge
    task automatic run_xfer(input logic [15:0] tx, input logic [15:0] sw, input bit lb,
                            input bit noise, input logic [15:0] noise_tx,
                            output logic [15:0] got_mosi);
        int cyc, done_cyc, cs_cnt, cs_first, rises, bad_mosi, bad_busy, extra_done;
        logic prev_sclk;
        logic [15:0] rx_at_done;
        loopback   = lb;
        slave_word = sw;
        slave_k    = 0;
        slave_bit  = 1'b0;
        got_mosi   = 16'h0000;
        @(negedge clk);
        m4.start   = 1'b1;
        m4.tx_data = tx;
        @(negedge clk);
        m4.start   = 1'b0;
        cyc = 1; done_cyc = -1; cs_cnt = 0; cs_first = -1; rises = 0;
        bad_mosi = 0; bad_busy = 0; prev_sclk = 1'b0; rx_at_done = 16'h0;
        while (done_cyc < 0 && cyc < 33 * D + 40) begin
            if (m4.cs) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = cyc;
            end
            if (m4.sclk && !prev_sclk) begin
                if (rises < 16) got_mosi[15 - rises] = m4.mosi;
                rises++;
            end
            if (!m4.cs && m4.mosi) bad_mosi++;
            if (m4.busy !== m4.cs) bad_busy++;
            if (m4.done) begin
                done_cyc   = cyc;
                rx_at_done = m4.rx_data;
            end
            prev_sclk = m4.sclk;
            if (noise) begin
                m4.tx_data = noise_tx ^ 16'($urandom_range(0, 1) * $urandom);
                m4.start   = (cyc < 33 * D - 2) && ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
            cyc++;
        end
        m4.start = 1'b0;
        chk("done_cycle", done_cyc, 33 * D + 1);
        chk("cs_first", cs_first, 1);
        chk("cs_cycles", cs_cnt, 33 * D);
        chk("sclk_rises", rises, 16);
        chk("mosi_order", got_mosi, wire_seq(tx));
        chk("mosi_idle_zero", bad_mosi, 0);
        chk("busy_eq_cs", bad_busy, 0);
        chk("rx_data", rx_at_done, lb ? tx : sw);
        extra_done = 0;
        repeat (10) begin
            if (m4.done || m4.cs) extra_done++;
            @(negedge clk);
        end
        chk("quiet_after", extra_done, 0);
        chk("rx_held", m4.rx_data, lb ? tx : sw);
    endtask

    // wait on the CLK_DIV=4 DUT for done, bounded; returns -1 on timeout
    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (m4.done) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] got;
        int          n, nd, ncs, d2_cyc, d8_cyc;
        reset = 1'b1;
        m4.start = 1'b0; m4.tx_data = 16'h0;
        m2.start = 1'b0; m2.tx_data = 16'h0;
        m8.start = 1'b0; m8.tx_data = 16'h0;
        loopback = 1'b1; slave_word = 16'h0; slave_k = 16; slave_bit = 1'b0;
        s2_shift = 16'h0; s8_shift = 16'h0; s2_word = 16'h0; s8_word = 16'h0;
        s2_rises = 0; s8_rises = 0;
        #1 reset = 1'b0;
        #1;
        chk("rst_sclk", m4.sclk, 0);
        chk("rst_mosi", m4.mosi, 0);
        chk("rst_cs", m4.cs, 0);
        chk("rst_busy", m4.busy, 0);
        chk("rst_done", m4.done, 0);
        chk("rst_rx", m4.rx_data, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // loopback of the reference word, plus its literal wire sequence
        run_xfer(16'hA53C, 16'h0, 1'b1, 1'b0, 16'h0, got);
        chk("a53c_wire", got, 16'h3CA5);

        // slave drives its own word on miso
        run_xfer(16'h0F0F, 16'hC3A5, 1'b0, 1'b0, 16'h0, got);

        // start pulses and tx_data churn while busy must be ignored
        run_xfer(16'h1234, 16'h0, 1'b1, 1'b1, 16'hFFFF, got);
        chk("ignore_wire", got, wire_seq(16'h1234));

        for (int t = 0; t < 6; t++) begin
            run_xfer(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 16'($urandom), got);
        end

        // back-to-back with start held high
        loopback = 1'b1;
        @(negedge clk);
        m4.start = 1'b1; m4.tx_data = 16'h00FF;
        @(negedge clk);
        m4.tx_data = 16'hFF00;
        wait_done(33 * D + 10, n);
        chk("b2b_first_done", n, 33 * D);
        chk("b2b_first_rx", m4.rx_data, 16'h00FF);
        chk("b2b_gap_cs_low", m4.cs, 0);
        @(negedge clk);
        m4.start = 1'b0;
        chk("b2b_gap_cs_back", m4.cs, 1);
        wait_done(33 * D + 10, n);
        chk("b2b_second_done", n, 33 * D);
        chk("b2b_second_rx", m4.rx_data, 16'hFF00);
        repeat (3) @(negedge clk);

        // reset in the middle of a transfer
        @(negedge clk);
        m4.start = 1'b1; m4.tx_data = 16'h6E91;
        @(negedge clk);
        m4.start = 1'b0;
        repeat (60) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_sclk", m4.sclk, 0);
        chk("mid_rst_mosi", m4.mosi, 0);
        chk("mid_rst_cs", m4.cs, 0);
        chk("mid_rst_busy", m4.busy, 0);
        chk("mid_rst_done", m4.done, 0);
        chk("mid_rst_rx", m4.rx_data, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        nd = 0; ncs = 0;
        repeat (150) begin
            @(negedge clk);
            if (m4.done) nd++;
            if (m4.cs) ncs++;
        end
        chk("post_rst_no_done", nd, 0);
        chk("post_rst_no_cs", ncs, 0);

        // start present at the very first edge after release
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m4.start = 1'b1; m4.tx_data = 16'h81E7;
        @(negedge clk);
        m4.start = 1'b0;
        chk("rel_accept_cs", m4.cs, 1);
        wait_done(33 * D + 10, n);
        chk("rel_done", n, 33 * D);
        chk("rel_rx", m4.rx_data, 16'h81E7);

        // CLK_DIV=2 and CLK_DIV=8 against the capturing slaves
        s2_rises = 0; s8_rises = 0;
        @(negedge clk);
        m2.start = 1'b1; m2.tx_data = 16'hBEEF;
        m8.start = 1'b1; m8.tx_data = 16'hBEEF;
        @(negedge clk);
        m2.start = 1'b0; m8.start = 1'b0;
        d2_cyc = -1; d8_cyc = -1;
        for (int c = 1; c < 33 * 8 + 40 && d8_cyc < 0; c++) begin
            if (m2.done && d2_cyc < 0) d2_cyc = c;
            if (m8.done) d8_cyc = c;
            if (d8_cyc < 0) @(negedge clk);
        end
        chk("d2_done", d2_cyc, 33 * 2 + 1);
        chk("d8_done", d8_cyc, 33 * 8 + 1);
        chk("d2_slave_word", s2_word, 16'hBEEF);
        chk("d8_slave_word", s8_word, 16'hBEEF);
        chk("d2_rises", s2_rises, 16);
        chk("d8_rises", s8_rises, 16);
        chk("d2_rx", m2.rx_data, 16'hBEEF);
        chk("d8_rx", m8.rx_data, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port start  input  1  request a 16-bit transfer; sampled only when busy=0.
REQ-005 SHALL have port tx_data  input  16  word to send; latched on accepted start.
REQ-006 SHALL have port miso  input  1  serial data from slave.
REQ-007 SHALL have port sclk  output  1  serial clock; idle low (mode 0).
REQ-008 SHALL have port mosi  output  1  serial data to slave.
REQ-009 SHALL have port cs  output  1  chip select, active-high (1 = slave selected).
REQ-010 SHALL have port busy  output  1  transfer in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-012 SHALL have port rx_data  output  16  last received word; held until the next done.

Function
REQ-013 SHALL implement states IDLE, SETUP, SCLK_HIGH, SCLK_LOW, HOLD, DONE; each timed state lasts exactly CLK_DIV cycles.
REQ-014 SHALL, in IDLE with start=1, latch tx_data and enter SETUP next cycle; start with busy=1 is ignored.
REQ-015 SHALL drive cs=1, busy=1 in SETUP, SCLK_HIGH, SCLK_LOW, HOLD; cs=0 in IDLE and DONE.
REQ-016 SHALL send bit order tx[7..0] then tx[15..8] (low byte first, MSB-first per byte).
REQ-017 SHALL present each mosi bit from SETUP/SCLK_LOW entry, holding it stable through the following SCLK_HIGH.
REQ-018 SHALL drive sclk=1 only in SCLK_HIGH; exactly 16 high phases per transfer, separated by 15 SCLK_LOW phases.
REQ-019 SHALL sample miso in the last clk cycle of each SCLK_HIGH; sampled bits 1-8 form rx[7:0] MSB-first, bits 9-16 form rx[15:8] MSB-first.
REQ-020 SHALL, after the 16th SCLK_HIGH, enter HOLD (sclk=0, cs=1), then DONE.
REQ-021 SHALL, in DONE (single cycle), assert done=1, busy=0, update rx_data with the assembled word; next state IDLE, or SETUP if start=1 in DONE.
REQ-022 SHALL, with start accepted at cycle 0, hold cs=1 for cycles 1..33*CLK_DIV and pulse done at cycle 33*CLK_DIV+1.
REQ-023 SHALL keep mosi=0 whenever cs=0.
REQ-024 SHALL use an internal 4-bit bit counter wrapping only by transfer completion; no partial transfers.
REQ-025 SHALL not change tx word mid-transfer when tx_data input changes.

Reset
REQ-026 SHALL, on reset=0 at any time (including mid-transfer), immediately force state=IDLE, sclk=0, mosi=0, cs=0, busy=0, done=0, rx_data=16'h0000, counters=0.
REQ-027 SHALL, after reset release, accept start on the first rising edge of clk with reset=1.

Verification
REQ-028 SHALL verify reset: reset=0 mid-transfer -> sclk, mosi, cs, busy, done = 0 and rx_data=0x0000 same cycle, no done afterwards.
REQ-029 SHALL verify loopback (miso=mosi), CLK_DIV=4, tx_data=0xA53C -> mosi at rising sclk edges 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1; cs=1 cycles 1..132; done at cycle 133; rx_data=0xA53C.
REQ-030 SHALL verify start pulses during busy with tx_data=0xFFFF -> ignored, original word 0x1234 transmitted, one done only.
REQ-031 SHALL verify back-to-back: start held high, words 0x00FF then 0xFF00 -> cs low exactly 1 cycle (DONE) between transfers, rx_data 0x00FF then 0xFF00 in loopback.
REQ-032 SHALL verify against spi_slave, CLK_DIV=2 and 8: send 0xBEEF -> slave received_data=0xBEEF after cs falls.
